mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
// - Parametrised MEM pipeline stage for the Mipu core: forwards the ALU result, serves LOADs from the D-cache on a hit.
// - On a LOAD miss or any STORE, runs a req/ack transaction to data memory and stalls the pipeline until it completes.
// - Registers the instruction, result and valid flag into the WB stage.
// PARAMETERS
// - DATA_W       16   datapath width: ALU result, store data, memory data
// - ADDR_W       16   data-memory address width
// - IR_W         16   instruction width; opcode is ir[IR_W-1:IR_W-5]
// - TIMEOUT_CYC  255  max BUSY cycles before bus error (MEM_TIMEOUT_EN only)
// PORTS
// - clock       in   1       core clock, all state on posedge
// - reset       in   1       asynchronous, active-high reset
// - run         in   1       pipeline exec strobe; stage advances only when 1
// - mem_ir      in   IR_W    instruction in MEM
// - alu_res     in   DATA_W  ALU result / effective address
// - store_data  in   DATA_W  STORE write data
// - cache_hit   in   1       D-cache hit for alu_res (same cycle)
// - cache_data  in   DATA_W  D-cache read data
// - d_req       out  1       memory request, registered
// - d_we        out  1       1 = write (STORE), registered
// - d_addr      out  ADDR_W  latched address
// - d_wdata     out  DATA_W  latched write data
// - d_rdata     in   DATA_W  memory read data, valid with d_ack
// - d_ack       in   1       single-cycle completion pulse
// - stall       out  1       combinational: freeze IF/ID/EX this cycle
// - wb_ir       out  IR_W    registered instruction to WB
// - wb_data     out  DATA_W  registered result to WB
// - wb_valid    out  1       wb_ir/wb_data valid this cycle
// - bus_err     out  1       one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
// - Reset: FSM=IDLE; d_req, d_we, wb_valid, bus_err = 0; d_addr, d_wdata, wb_ir (NOP=0), wb_data = 0.
// - FSM: IDLE, BUSY. Address = alu_res[ADDR_W-1:0]; zero-extended if ADDR_W > DATA_W.
// - IDLE, run=0: all registers hold, stall=0.
// - IDLE, run=1, non-mem op: 1-cycle pass.
//   - wb_ir <= mem_ir, wb_data <= alu_res, wb_valid <= 1.
// - IDLE, run=1, LOAD and cache_hit: 1-cycle pass, wb_data <= cache_data, no memory access.
// - IDLE, run=1, LOAD miss or STORE:
//   - stall=1 that cycle; next state BUSY.
//   - d_req <= 1, d_we <= is_store; d_addr and d_wdata latched.
//   - wb_valid <= 0 and wb_ir <= NOP (bubble).
// - BUSY:
//   - d_req, d_we, d_addr, d_wdata held stable; stall = ~d_ack; progresses regardless of run.
//   - On d_ack: d_req <= 0, IDLE, wb_ir <= mem_ir, wb_valid <= 1.
//   - wb_data <= d_rdata for LOAD, alu_res for STORE.
// - d_ack in IDLE is ignored. Ack latency from d_req rise is >= 1 cycle, since d_req is registered.
// - Reset mid-BUSY: d_req drops asynchronously; a late ack after reset is ignored.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - BUSY cycles are counted; reaching TIMEOUT_CYC without d_ack acts like an ack.
//   - On timeout: d_req <= 0, IDLE, wb_valid <= 1; LOAD wb_data <= all ones; bus_err pulses for 1 cycle.
//   - Ack and timeout in the same cycle: ack wins, no bus_err.
// - MEM_TIMEOUT_EN undefined: no counter, bus_err tied 0, BUSY waits indefinitely.
// STRUCTURE
// - Shared package mipu_pkg: opcode constants (LOAD, STORE), NOP encoding, FSM state encoding.
// - Sub-module mem_timeout_cnt (clear, enable, expire), instantiated only under MEM_TIMEOUT_EN.
// TESTING
// - ADD, alu_res=0x1234, run=1 -> next cycle wb_data=0x1234, wb_valid=1, stall never high.
// - LOAD, cache_hit=1, cache_data=0xBEEF -> wb_data=0xBEEF after 1 cycle, d_req stays 0.
// - LOAD miss at 0x0040, ack 3 cycles after d_req:
//   - d_addr=0x0040, d_we=0; stall high 4 cycles; wb_data=d_rdata=0xCAFE.
//   - wb_valid=0 during the stall, 1 after.
// - STORE 0x5A5A to 0x0010, ack after 1 cycle -> d_we=1, d_wdata=0x5A5A, wb_data=0x0010, d_req low after ack.
// - Reset asserted in BUSY, then ack pulsed -> d_req=0 at once, FSM IDLE, no wb_valid from the ack.
// - MEM_TIMEOUT_EN, TIMEOUT_CYC=4, LOAD miss, no ack -> bus_err pulse, wb_data=0xFFFF, stall released.

Source files
------------

// File: rtl/mipu_pkg.sv
// Shared Mipu core definitions: instruction opcode field, memory opcodes,
// the NOP encoding and the MEM-stage FSM state encoding.
package mipu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'b01000;
    localparam logic [OP_W-1:0] OP_STORE = 5'b01001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle watchdog for the MEM stage; expire_o is high during the LIMIT-th
// enabled cycle after a clear. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Mipu MEM stage: ALU pass-through, D-cache load hits, stalling req/ack memory access.
// Define MEM_TIMEOUT_EN to add a BUSY watchdog that ends the access with bus_err.
module mem_stage_ctrl
    import mipu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int IR_W        = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic [IR_W-1:0]   mem_ir_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic              cache_hit_i,
    input  logic [DATA_W-1:0] cache_data_i,
    output logic              d_req_o,
    output logic              d_we_o,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic [DATA_W-1:0] d_wdata_o,
    input  logic [DATA_W-1:0] d_rdata_i,
    input  logic              d_ack_i,
    output logic              stall_o,
    output logic [IR_W-1:0]   wb_ir_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic              bus_err_o
);

    mem_state_e        state_q, state_d;
    logic              d_req_q, d_req_d;
    logic              d_we_q, d_we_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic [IR_W-1:0]   wb_ir_q, wb_ir_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              bus_err_q, bus_err_d;

    logic [OP_W-1:0]   opcode;
    logic              is_load, is_store, need_mem;
    logic              timeout, mem_done;

    assign opcode   = mem_ir_i[IR_W-1 -: OP_W];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign need_mem = is_store || (is_load && !cache_hit_i);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_cnt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (state_q != ST_BUSY),
        .enable_i(state_q == ST_BUSY),
        .expire_o(timeout)
    );
`else
    // TIMEOUT_CYC only matters when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    assign mem_done = d_ack_i || timeout;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            d_req_q    <= 1'b0;
            d_we_q     <= 1'b0;
            d_addr_q   <= '0;
            d_wdata_q  <= '0;
            wb_ir_q    <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_req_q    <= d_req_d;
            d_we_q     <= d_we_d;
            d_addr_q   <= d_addr_d;
            d_wdata_q  <= d_wdata_d;
            wb_ir_q    <= wb_ir_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run_i && need_mem) state_d = ST_BUSY;
            ST_BUSY: if (mem_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o    = 1'b0;
        d_req_d    = d_req_q;
        d_we_d     = d_we_q;
        d_addr_d   = d_addr_q;
        d_wdata_d  = d_wdata_q;
        wb_ir_d    = wb_ir_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = wb_valid_q;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i && need_mem) begin
                    // Launch the access and push a NOP bubble into WB meanwhile.
                    stall_o    = 1'b1;
                    d_req_d    = 1'b1;
                    d_we_d     = is_store;
                    d_addr_d   = ADDR_W'(alu_res_i);
                    d_wdata_d  = store_data_i;
                    wb_ir_d    = '0;
                    wb_valid_d = 1'b0;
                end else if (run_i) begin
                    wb_ir_d    = mem_ir_i;
                    wb_data_d  = is_load ? cache_data_i : alu_res_i;
                    wb_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                stall_o = !mem_done;
                if (mem_done) begin
                    // The latched write flag tells load from store; a timed-out load returns all ones.
                    d_req_d    = 1'b0;
                    wb_ir_d    = mem_ir_i;
                    wb_valid_d = 1'b1;
                    wb_data_d  = d_we_q ? alu_res_i : (d_ack_i ? d_rdata_i : '1);
                    bus_err_d  = timeout && !d_ack_i;
                end
            end
            default: ;
        endcase
    end

    assign d_req_o    = d_req_q;
    assign d_we_o     = d_we_q;
    assign d_addr_o   = d_addr_q;
    assign d_wdata_o  = d_wdata_q;
    assign wb_ir_o    = wb_ir_q;
    assign wb_data_o  = wb_data_q;
    assign wb_valid_o = wb_valid_q;
    assign bus_err_o  = bus_err_q;

endmodule
